// File: rtl/range_pkg.sv
// Shared definitions for the range-finding sender/receiver pair.
package range_pkg;

  // Transmit state of the sender.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Default data word width, shared with the receiver.
  localparam int RANGE_WIDTH = 16;

  // Default burst buffer capacity in words.
  localparam int RANGE_DEPTH = 8;

endpackage : range_pkg

// File: rtl/range_stream_sender_if.sv
// Host-side load/control signals and the go...finish frame stream of the sender.
interface range_stream_sender_if
  import range_pkg::*;
#(
  parameter int WIDTH = RANGE_WIDTH,
  parameter int DEPTH = RANGE_DEPTH
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             load_en;
  logic [WIDTH-1:0] load_data;
  logic             clear;
  logic             start;
  logic             go;
  logic             finish;
  logic [WIDTH-1:0] data_out;
  logic             busy;
  logic [CW-1:0]    count;
  logic             load_err;
  logic             start_err;
  logic [WIDTH-1:0] exp_range;
  logic             exp_valid;

  // The sender: takes load/control, drives the frame and status.
  modport master (
    input  load_en, load_data, clear, start,
    output go, finish, data_out, busy, count,
           load_err, start_err, exp_range, exp_valid
  );

  // The host/consumer side.
  modport slave (
    output load_en, load_data, clear, start,
    input  go, finish, data_out, busy, count,
           load_err, start_err, exp_range, exp_valid
  );

endinterface : range_stream_sender_if

// File: rtl/range_tracker.sv
// Running max/min of a frame; captures max - min when the frame ends.
module range_tracker
  import range_pkg::*;
#(
  parameter int WIDTH = RANGE_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load_i,     // first word of frame: seed max/min
  input  logic             update_i,   // later words: fold into max/min
  input  logic             capture_i,  // last word: publish range
  input  logic [WIDTH-1:0] word_i,
  output logic [WIDTH-1:0] exp_range_o,
  output logic             exp_valid_o
);

  logic [WIDTH-1:0] max_q;
  logic [WIDTH-1:0] min_q;
  logic [WIDTH-1:0] max_d;
  logic [WIDTH-1:0] min_d;
  logic [WIDTH-1:0] exp_range_q;
  logic             exp_valid_q;

  // Max/min including the word currently on the wire (unsigned compares).
  always_comb begin
    max_d = max_q;
    min_d = min_q;
    if (word_i > max_q) begin
      max_d = word_i;
    end else begin
      max_d = max_q;
    end
    if (word_i < min_q) begin
      min_d = word_i;
    end else begin
      min_d = min_q;
    end
  end

  // Track extremes and publish the range at the end of each frame.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      max_q       <= '0;
      min_q       <= '0;
      exp_range_q <= '0;
      exp_valid_q <= 1'b0;
    end else begin
      if (load_i) begin
        max_q <= word_i;
        min_q <= word_i;
      end else if (update_i) begin
        max_q <= max_d;
        min_q <= min_d;
      end
      // max_d >= min_d always holds, so the difference never wraps.
      if (capture_i) begin
        exp_range_q <= max_d - min_d;
      end
      exp_valid_q <= capture_i;
    end
  end

  assign exp_range_o = exp_range_q;
  assign exp_valid_o = exp_valid_q;

endmodule : range_tracker

// File: rtl/range_stream_sender.sv
// Buffers a burst of words and replays it as one contiguous go...finish frame,
// computing the expected max - min of the burst alongside.
module range_stream_sender
  import range_pkg::*;
#(
  parameter int WIDTH = RANGE_WIDTH,
  parameter int DEPTH = RANGE_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  range_stream_sender_if.master  bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  tx_state_t        state_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    index_q;
  logic             go_q;
  logic             finish_q;
  logic             busy_q;
  logic [WIDTH-1:0] data_q;
  logic             load_err_q;
  logic             start_err_q;

  logic             full_s;
  logic             start_ok_s;
  logic             start_rej_s;
  logic             load_ok_s;
  logic             load_rej_s;
  logic             last_s;
  logic [CW-1:0]    next_index_s;

  // Accept/reject decisions for this cycle's start and load requests.
  always_comb begin
    full_s       = (count_q == CW'(DEPTH));
    // clear wins over start; a burst shorter than 2 cannot form a frame.
    start_ok_s   = bus.start && (state_q == IDLE) && (count_q >= CW'(2)) && !bus.clear;
    start_rej_s  = bus.start && !start_ok_s;
    // A load may not race a starting frame, a clear, or a full buffer.
    load_ok_s    = bus.load_en && (state_q == IDLE) && !full_s && !start_ok_s && !bus.clear;
    load_rej_s   = bus.load_en && !load_ok_s;
    last_s       = (index_q == (count_q - CW'(1)));
    next_index_s = index_q + CW'(1);
  end

  // Burst storage; contents persist across frames so a start replays them.
  always_ff @(posedge clock) begin
    if (load_ok_s) begin
      mem_q[count_q[AW-1:0]] <= bus.load_data;
    end
  end

  // Control FSM with registered frame outputs aligned to state/index.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      index_q     <= '0;
      go_q        <= 1'b0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
      data_q      <= '0;
      load_err_q  <= 1'b0;
      start_err_q <= 1'b0;
    end else begin
      load_err_q  <= load_rej_s;
      start_err_q <= start_rej_s;
      case (state_q)
        IDLE: begin
          if (bus.clear) begin
            count_q <= '0;
          end else if (load_ok_s) begin
            count_q <= count_q + CW'(1);
          end
          if (start_ok_s) begin
            state_q  <= SEND;
            index_q  <= '0;
            go_q     <= 1'b1;
            finish_q <= 1'b0;
            busy_q   <= 1'b1;
            data_q   <= mem_q[0];
          end else begin
            index_q  <= '0;
            go_q     <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
          end
        end
        SEND: begin
          // clear is deliberately ignored here: a frame always completes.
          if (last_s) begin
            state_q  <= IDLE;
            index_q  <= '0;
            go_q     <= 1'b0;
            finish_q <= 1'b0;
            busy_q   <= 1'b0;
            data_q   <= '0;
          end else begin
            index_q  <= next_index_s;
            go_q     <= 1'b0;
            finish_q <= (next_index_s == (count_q - CW'(1)));
            busy_q   <= 1'b1;
            data_q   <= mem_q[next_index_s[AW-1:0]];
          end
        end
        default: begin
          state_q  <= IDLE;
          index_q  <= '0;
          go_q     <= 1'b0;
          finish_q <= 1'b0;
          busy_q   <= 1'b0;
          data_q   <= '0;
        end
      endcase
    end
  end

  range_tracker #(
    .WIDTH (WIDTH)
  ) u_tracker (
    .clock       (clock),
    .reset_n     (reset_n),
    .load_i      (go_q),
    .update_i    (busy_q && !go_q),
    .capture_i   (finish_q),
    .word_i      (data_q),
    .exp_range_o (bus.exp_range),
    .exp_valid_o (bus.exp_valid)
  );

  assign bus.go        = go_q;
  assign bus.finish    = finish_q;
  assign bus.data_out  = data_q;
  assign bus.busy      = busy_q;
  assign bus.count     = count_q;
  assign bus.load_err  = load_err_q;
  assign bus.start_err = start_err_q;

endmodule : range_stream_sender

// File: doc/range_stream_sender.md
Name: range_stream_sender

Overview:
- Transmit-side partner of the go/finish range-finding receiver.
- Software or a testbench loads a burst of up to DEPTH words into an internal buffer. On start, the block replays the burst as one contiguous go...finish frame, one word per cycle.
- It also computes the expected range (max - min) of the burst, so the system can self-check against the receiver's range output.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 8, buffer capacity in words; must be at least 2.
- CW, $clog2(DEPTH+1), count width (derived; do not override).

Ports:
- clock  input  1  system clock, all state on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- load_en  input  1  append load_data to buffer this cycle.
- load_data  input  WIDTH  word to append.
- clear  input  1  empty the buffer (count := 0).
- start  input  1  request transmission of the buffered burst.
- go  output  1  high for the first word of a frame only.
- finish  output  1  high for the last word of a frame only.
- data_out  output  WIDTH  word being transmitted; 0 when idle.
- busy  output  1  high while a frame is on the wire.
- count  output  CW  number of words currently buffered.
- load_err  output  1  one-cycle pulse: a load was dropped.
- start_err  output  1  one-cycle pulse: a start was rejected.
- exp_range  output  WIDTH  max - min of the last completed frame.
- exp_valid  output  1  one-cycle pulse when exp_range updates.

Behaviour:
- Reset (reset_n low, asynchronous):
  - State = IDLE; count, index, max, min and exp_range = 0.
  - All outputs = 0.
  - Buffer contents are don't-care.
- States:
  - IDLE: loading allowed; go, finish and data_out are 0.
  - SEND: busy = 1; index runs from 0 to count-1.
  - IDLE → SEND when start is accepted.
  - SEND → IDLE on the edge ending the index == count-1 cycle.
- Outputs go, finish, data_out and busy decode only from registered state/index/buffer. There is no combinational path from inputs.
- Start acceptance: start is accepted in IDLE only when count ≥ 2 and clear is low.
  - Latency: go = 1 in the cycle immediately after acceptance.
  - In SEND: data_out = buf[index], go = (index == 0), finish = (index == count-1).
  - Because count ≥ 2, go and finish are never high together.
  - The frame is exactly count cycles with no gaps; valid data is presented every cycle between go and finish inclusive.
- start is rejected (start_err pulses in the next cycle, no state change) when any of these holds:
  - state is SEND, including the finish cycle;
  - count < 2;
  - clear is high in the same cycle.
- Loads:
  - In IDLE with count < DEPTH: buf[count] := load_data, count := count + 1.
  - A load is dropped, with a load_err pulse, when any of these holds:
    - buffer full (count == DEPTH);
    - state is SEND;
    - start is accepted in the same cycle;
    - clear is high in the same cycle.
- clear:
  - In IDLE: count := 0. clear has priority over start and load.
  - In SEND: clear is ignored with no flag; the frame always completes.
- Buffer persistence: the buffer is retained after a frame, so a new start replays the same burst.
  - Back-to-back frames: start in the cycle after finish is accepted.
  - The minimum gap between finish and the next go is therefore 1 idle cycle.
- Expected range:
  - max and min are loaded with buf[0] on the go cycle and updated with unsigned compares on each later SEND cycle.
  - On the edge ending the finish cycle: exp_range := max' - min', where max'/min' include the finish word. exp_valid pulses in the following cycle.
  - exp_range holds until the next frame completes.
  - Subtraction is unsigned WIDTH-bit and cannot underflow (max ≥ min).
- Reset mid-frame aborts immediately. All outputs drop in the same instant. Downstream sees a truncated frame and must itself be reset.

Decomposition:
- Shared package range_pkg:
  - typedef enum logic {IDLE, SEND} tx_state_t;
  - the default WIDTH constant, shared with the receiver.
- One natural sub-module: range_tracker. It holds the running max/min with a load/update/capture interface and produces exp_range/exp_valid.
- The buffer stays inline as a simple register array.

Test Plan:
- Load 5, 9, 2, 7; start → go with 5 one cycle later; data 5, 9, 2, 7 on consecutive cycles; finish with 7; exp_range = 7 and exp_valid pulse the cycle after finish; busy exactly 4 cycles.
- Load single word 3, then start → start_err pulse, go never asserts. Load 3 again, then start → 2-word frame 3, 3 and exp_range = 0.
- Fill 8 words, then load a 9th → load_err pulse, count stays 8. Start during the frame → start_err. load_en mid-frame → load_err. Frame unaffected.
- Frame of 16'hFFFF, 16'h0000 → exp_range = 16'hFFFF. start in the cycle after finish → second identical frame; go one cycle after the start.
- Same cycle start + clear with count = 4 → count = 0, start_err pulse, no go. Same cycle start + load_en with count = 3 → frame of 3 words, load_err, count stays 3.
- Drop reset_n low during the 2nd word of a 6-word frame → go, finish, busy, data_out and count go to 0 asynchronously; after release, IDLE with count = 0.
